adc_word_unpacker: RTL

- Sits in the clk_100M domain, downstream of the ADC capture block.
- Accepts the 128-bit packed CH1/CH2 sample words, each marked by a single-cycle strobe (the synchronized rising edge of the word-valid). Buffers them in per-channel word FIFOs.
- Re-serializes them into a paired 16-bit sample stream with a valid/ready handshake for the algorithm and DAC feedback path.
- Flags lost words and pairing mismatches.

---
 rtl/adc_word_unpacker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adc_word_unpacker.sv
// Buffers packed 8x16-bit CH1/CH2 ADC words in per-channel FIFOs and replays
// them as a paired 16-bit sample stream with a valid/ready handshake.

module adc_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                     clk_100M,
  input  logic                     ch_A_rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
    if (!ch_A_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // On a full FIFO a simultaneous push overwrites the slot being popped;
  // dout is read combinationally before the edge, so the old word is taken.
  always_ff @(posedge clk_100M) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
endmodule

module adc_word_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_100M,
  input  logic             ch_A_rst_n,
  input  logic             clear,
  input  logic [127:0]     word_ch1,
  input  logic             word_stb_ch1,
  input  logic [127:0]     word_ch2,
  input  logic             word_stb_ch2,
  input  logic             smp_ready,
  output logic [15:0]      smp_ch1,
  output logic [15:0]      smp_ch2,
  output logic             smp_valid,
  output logic             smp_first,
  output logic             smp_last,
  output logic [CNT_W-1:0] word_count,
  output logic             overflow_ch1,
  output logic             overflow_ch2,
  output logic             pair_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW+1:0] ONE      = (AW+2)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t                 state;
  logic [1:0][127:0]      word_in, head, shift;
  logic [1:0]             stb, full, nonempty, push, drop;
  logic [1:0][AW:0]       level;
  logic [2:0]             lane;
  logic                   pop, both_ne, imbalance;
  logic [AW+1:0]          lvl1, lvl2;

  assign word_in = {word_ch2, word_ch1};
  assign stb     = {word_stb_ch2, word_stb_ch1};
  assign pop     = (state == LOAD) && !clear;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    assign full[c]     = (level[c] == FULL_LVL);
    assign nonempty[c] = (level[c] != '0);
    assign push[c]     = stb[c] && !clear && (!full[c] || pop);
    assign drop[c]     = stb[c] && !clear && full[c] && !pop;

    adc_word_fifo #(.DEPTH(FIFO_DEPTH), .W(128)) u_fifo (
      .clk_100M   (clk_100M),
      .ch_A_rst_n (ch_A_rst_n),
      .clear      (clear),
      .push       (push[c]),
      .pop        (pop),
      .din        (word_in[c]),
      .dout       (head[c]),
      .level      (level[c])
    );
  end

  assign both_ne   = &nonempty;
  assign lvl1      = {1'b0, level[0]};
  assign lvl2      = {1'b0, level[1]};
  assign imbalance = (lvl1 > lvl2 + ONE) || (lvl2 > lvl1 + ONE);

  // Lane 0 sits at the top of each word, so the output is always the MSB slice.
  assign smp_ch1 = shift[0][127:112];
  assign smp_ch2 = shift[1][127:112];

  always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
    if (!ch_A_rst_n) begin
      state        <= IDLE;
      shift        <= '0;
      lane         <= '0;
      smp_valid    <= 1'b0;
      smp_first    <= 1'b0;
      smp_last     <= 1'b0;
      word_count   <= '0;
      overflow_ch1 <= 1'b0;
      overflow_ch2 <= 1'b0;
      pair_err     <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      shift        <= '0;
      lane         <= '0;
      smp_valid    <= 1'b0;
      smp_first    <= 1'b0;
      smp_last     <= 1'b0;
      word_count   <= '0;
      overflow_ch1 <= 1'b0;
      overflow_ch2 <= 1'b0;
      pair_err     <= 1'b0;
    end else begin
      overflow_ch1 <= overflow_ch1 | drop[0];
      overflow_ch2 <= overflow_ch2 | drop[1];
      pair_err     <= pair_err | imbalance;
      case (state)
        IDLE: if (both_ne) state <= LOAD;
        LOAD: begin
          shift     <= head;
          lane      <= '0;
          smp_valid <= 1'b1;
          smp_first <= 1'b1;
          smp_last  <= 1'b0;
          state     <= EMIT;
        end
        EMIT: if (smp_ready) begin
          for (int c = 0; c < 2; c++) shift[c] <= {shift[c][111:0], 16'h0000};
          lane      <= lane + 3'd1;
          smp_first <= 1'b0;
          smp_last  <= (lane == 3'd6);
          if (lane == 3'd7) begin
            word_count <= word_count + 1'b1;
            smp_valid  <= 1'b0;
            smp_last   <= 1'b0;
            state      <= both_ne ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
